hazard_unit: RTL and testbench



---
 rtl/core_pkg.sv | 9 +
 rtl/hazard_unit_fwd_select.sv | 21 ++
 rtl/hazard_unit.sv | 101 ++++++++++
 tb/tb_hazard_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: forwarding mux select codes and register index width.
package core_pkg;
   localparam int REG_ADDR_W_DEFAULT = 5;

   // Order matches the EX operand mux inputs: register file, writeback, MEM-stage ALU result.
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/hazard_unit_fwd_select.sv
// Per-operand forwarding select: purely combinational priority compare, MEM producer beats WB.
module fwd_select
   import core_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] rd_m,
   input  logic                  reg_write_m,
   input  logic [REG_ADDR_W-1:0] rd_w,
   input  logic                  reg_write_w,
   output logic [1:0]            sel
);
   always_comb begin
      sel = FWD_RF;
      if (reg_write_m && (rd_m != '0) && (rd_m == rs))
         sel = FWD_MEM;
      else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
         sel = FWD_WB;
   end
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: shadow tag pipeline, operand forwarding, load-use stall and branch flush.
// Optional performance counters enabled by HAZARD_PERF_EN.
module hazard_unit
   import core_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
`ifdef HAZARD_PERF_EN
  ,parameter int PERF_W     = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rd_d,
   input  logic                  reg_write_d,
   input  logic                  mem_read_d,
   input  logic                  pc_src_e,
   output logic [1:0]            forward_a_e,
   output logic [1:0]            forward_b_e,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d,
   output logic                  flush_e
`ifdef HAZARD_PERF_EN
  ,output logic [PERF_W-1:0]     stall_count,
   output logic [PERF_W-1:0]     flush_count
`endif
);
   logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic                  reg_write_e, mem_read_e, reg_write_m, reg_write_w;
   logic                  lw_stall, stall_raw, flush_e_raw;
   logic [1:0]            sel_a, sel_b;

   assign lw_stall    = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
   // A taken branch squashes the stalled decode instruction, so it overrides the stall.
   assign stall_raw   = lw_stall && !pc_src_e;
   assign flush_e_raw = lw_stall || pc_src_e;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs1_e       <= '0;
         rs2_e       <= '0;
         rd_e        <= '0;
         reg_write_e <= 1'b0;
         mem_read_e  <= 1'b0;
         rd_m        <= '0;
         reg_write_m <= 1'b0;
         rd_w        <= '0;
         reg_write_w <= 1'b0;
      end else begin
         rd_w        <= rd_m;
         reg_write_w <= reg_write_m;
         rd_m        <= rd_e;
         reg_write_m <= reg_write_e;
         if (flush_e_raw) begin
            rs1_e       <= '0;
            rs2_e       <= '0;
            rd_e        <= '0;
            reg_write_e <= 1'b0;
            mem_read_e  <= 1'b0;
         end else begin
            rs1_e       <= rs1_d;
            rs2_e       <= rs2_d;
            rd_e        <= rd_d;
            reg_write_e <= reg_write_d;
            mem_read_e  <= mem_read_d;
         end
      end
   end

   fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .rs(rs1_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
      .rd_w(rd_w), .reg_write_w(reg_write_w), .sel(sel_a)
   );

   fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .rs(rs2_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
      .rd_w(rd_w), .reg_write_w(reg_write_w), .sel(sel_b)
   );

   // Every output is forced low during reset, including the direct pc_src_e path.
   assign forward_a_e = reset ? FWD_RF : sel_a;
   assign forward_b_e = reset ? FWD_RF : sel_b;
   assign stall_f     = !reset && stall_raw;
   assign stall_d     = !reset && stall_raw;
   assign flush_d     = !reset && pc_src_e;
   assign flush_e     = !reset && flush_e_raw;

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_raw) stall_count <= stall_count + 1'b1;
         if (pc_src_e)  flush_count <= flush_count + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; counter checks compile in with HAZARD_PERF_EN.
module tb_hazard_unit;
   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs1_d, rs2_d, rd_d;
   logic       reg_write_d, mem_read_d, pc_src_e;
   logic [1:0] forward_a_e, forward_b_e;
   logic       stall_f, stall_d, flush_d, flush_e;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_count, flush_count;
`endif
   int checks = 0;
   int errors = 0;
   logic [7:0] obs;

   always #5 clk = ~clk;

   hazard_unit dut (
      .clk(clk), .reset(reset),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .reg_write_d(reg_write_d), .mem_read_d(mem_read_d), .pc_src_e(pc_src_e),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e)
`ifdef HAZARD_PERF_EN
     ,.stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   // obs packs {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e}
   assign obs = {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic br);
      rs1_d = rs1; rs2_d = rs2; rd_d = rd;
      reg_write_d = wr; mem_read_d = ld; pc_src_e = br;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 1);
      checks++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b", obs, 8'h00);
      end
      do_reset();
      checks++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL post_reset_idle got=%b exp=%b", obs, 8'h00);
      end
   endtask

   task automatic test_fwd_mem();
      do_reset();
      drive(0, 0, 5, 1, 0, 0);     // add x5
      tick();
      drive(5, 0, 0, 0, 0, 0);     // consumer of x5 on rs1
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 8'b10_00_0000) begin
         errors++;
         $display("FAIL fwd_mem_a got=%b exp=%b", obs, 8'b10_00_0000);
      end
      tick();
      checks++;
      if (obs !== 8'b00_00_0000) begin
         errors++;
         $display("FAIL fwd_mem_after got=%b exp=%b", obs, 8'b00_00_0000);
      end
   endtask

   task automatic test_fwd_priority();
      do_reset();
      drive(0, 0, 7, 1, 0, 0);
      tick();
      drive(0, 0, 7, 1, 0, 0);
      tick();
      drive(0, 7, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 8'b00_10_0000) begin
         errors++;
         $display("FAIL fwd_mem_over_wb got=%b exp=%b", obs, 8'b00_10_0000);
      end
      do_reset();
      drive(0, 0, 7, 1, 0, 0);
      tick();
      drive(0, 0, 7, 0, 0, 0);     // younger instr targets x7 but does not write
      tick();
      drive(0, 7, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 8'b00_01_0000) begin
         errors++;
         $display("FAIL fwd_wb got=%b exp=%b", obs, 8'b00_01_0000);
      end
      do_reset();
      drive(0, 0, 9, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      drive(9, 9, 0, 0, 0, 0);     // both operands pick up x9 from WB
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 8'b01_01_0000) begin
         errors++;
         $display("FAIL fwd_wb_both got=%b exp=%b", obs, 8'b01_01_0000);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(0, 0, 3, 1, 1, 0);     // lw x3
      tick();
      drive(0, 3, 0, 0, 0, 0);     // consumer of x3 on rs2
      checks++;
      if (obs !== 8'b00_00_1101) begin
         errors++;
         $display("FAIL lw_stall got=%b exp=%b", obs, 8'b00_00_1101);
      end
      tick();                      // consumer held in decode, bubble in EX
      checks++;
      if (obs !== 8'b00_00_0000) begin
         errors++;
         $display("FAIL lw_stall_one_cycle got=%b exp=%b", obs, 8'b00_00_0000);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 8'b00_01_0000) begin
         errors++;
         $display("FAIL lw_fwd_wb got=%b exp=%b", obs, 8'b00_01_0000);
      end
   endtask

   task automatic test_branch();
      do_reset();
      drive(0, 0, 3, 1, 1, 0);
      tick();
      drive(0, 3, 0, 0, 0, 1);     // load-use coinciding with taken branch
      checks++;
      if (obs !== 8'b00_00_0011) begin
         errors++;
         $display("FAIL branch_over_stall got=%b exp=%b", obs, 8'b00_00_0011);
      end
      do_reset();
      drive(1, 2, 4, 1, 0, 1);
      checks++;
      if (obs !== 8'b00_00_0011) begin
         errors++;
         $display("FAIL branch_only got=%b exp=%b", obs, 8'b00_00_0011);
      end
      tick();                      // flushed instr must not appear as a producer
      drive(4, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 8'b00_00_0000) begin
         errors++;
         $display("FAIL branch_bubble got=%b exp=%b", obs, 8'b00_00_0000);
      end
   endtask

   task automatic test_x0();
      do_reset();
      drive(0, 0, 0, 1, 1, 0);     // lw x0
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 8'b00_00_0000) begin
         errors++;
         $display("FAIL x0_no_stall got=%b exp=%b", obs, 8'b00_00_0000);
      end
      tick();
      checks++;
      if (obs !== 8'b00_00_0000) begin
         errors++;
         $display("FAIL x0_no_fwd_mem got=%b exp=%b", obs, 8'b00_00_0000);
      end
      tick();
      checks++;
      if (obs !== 8'b00_00_0000) begin
         errors++;
         $display("FAIL x0_no_fwd_wb got=%b exp=%b", obs, 8'b00_00_0000);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(0, 0, 3, 1, 1, 0);
      tick();
      drive(3, 0, 0, 0, 0, 1);
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_stall got=%b exp=%b", obs, 8'h00);
      end
      tick();
      drive(3, 3, 0, 0, 0, 0);
      reset = 1'b0;
      #1;
      checks++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL after_reset_no_hazard got=%b exp=%b", obs, 8'h00);
      end
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 6, 1, 1, 0);
         tick();
         drive(6, 0, 0, 0, 0, 0);
         tick();
         drive(0, 0, 0, 0, 0, 0);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (stall_count !== 32'd3) begin
         errors++;
         $display("FAIL stall_count got=%0d exp=%0d", stall_count, 3);
      end
      checks++;
      if (flush_count !== 32'd2) begin
         errors++;
         $display("FAIL flush_count got=%0d exp=%0d", flush_count, 2);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({stall_count, flush_count} !== 64'd0) begin
         errors++;
         $display("FAIL count_reset got=%0d/%0d exp=0/0", stall_count, flush_count);
      end
      reset = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_fwd_mem();
      test_fwd_priority();
      test_load_use();
      test_branch();
      test_x0();
      test_reset_mid_stall();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
